// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame writer: FSM state encoding and window sizing helper.
package cam_pkg;

   localparam int unsigned PIX_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_VS = 3'd1,
      ST_SYNC    = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_DONE    = 3'd4
   } cam_state_e;

   // Number of pixels in the crop window, i.e. the number of RAM writes per frame.
   function automatic int unsigned win_pixels(input int unsigned w, input int unsigned h);
      return w * h;
   endfunction

endpackage

// File: rtl/cam_win_counter.sv
// Pixel x/y position tracking with saturation and crop-window hit detection.
// CAM_DOWNSCALE_EN: keep only even raw x/y pixels and compare the window in halved coordinates.
module cam_win_counter
   import cam_pkg::*;
#(
   parameter int unsigned SRC_W  = 640,
   parameter int unsigned SRC_H  = 480,
   parameter int unsigned WIN_X0 = 0,
   parameter int unsigned WIN_Y0 = 0,
   parameter int unsigned WIN_W  = 256,
   parameter int unsigned WIN_H  = 240
) (
   input  logic csi_pclk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic step_i,
   input  logic line_end_i,
   output logic win_hit_c_o
);

`ifdef CAM_DOWNSCALE_EN
   localparam int unsigned SCALE = 2;
`else
   localparam int unsigned SCALE = 1;
`endif
   localparam int unsigned X_LIM = SRC_W * SCALE;
   localparam int unsigned Y_LIM = SRC_H * SCALE;
   localparam int unsigned XW    = $clog2(X_LIM + 1);
   localparam int unsigned YW    = $clog2(Y_LIM + 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [XW-1:0] xs;
   logic [YW-1:0] ys;
   logic          keep;

`ifdef CAM_DOWNSCALE_EN
   assign xs   = x_q >> 1;
   assign ys   = y_q >> 1;
   assign keep = ~x_q[0] & ~y_q[0];
`else
   assign xs   = x_q;
   assign ys   = y_q;
   assign keep = 1'b1;
`endif

   // Raw counters saturate at the (scaled) source size so overlong lines/frames are ignored.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (line_end_i) begin
         x_d = '0;
         if (32'(y_q) < Y_LIM) y_d = y_q + YW'(1);
      end else if (step_i && (32'(x_q) < X_LIM)) begin
         x_d = x_q + XW'(1);
      end
   end

   always_ff @(posedge csi_pclk or negedge reset_n) begin
      if (!reset_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign win_hit_c_o = keep
                      && (32'(xs) >= WIN_X0) && (32'(xs) < WIN_X0 + WIN_W)
                      && (32'(ys) >= WIN_Y0) && (32'(ys) < WIN_Y0 + WIN_H);

endmodule

// File: rtl/cam_frame_writer.sv
// Crops a window out of the incoming RGB565 pixel stream and writes it linearly to a frame-buffer RAM port.
module cam_frame_writer
   import cam_pkg::*;
#(
   parameter int unsigned SRC_W  = 640,
   parameter int unsigned SRC_H  = 480,
   parameter int unsigned WIN_X0 = 0,
   parameter int unsigned WIN_Y0 = 0,
   parameter int unsigned WIN_W  = 256,
   parameter int unsigned WIN_H  = 240,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              csi_pclk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              vsync,
   input  logic              href,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              short_err
);

   localparam int unsigned       WIN_PIXELS = win_pixels(WIN_W, WIN_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIN_PIXELS - 1);

   if (64'(WIN_PIXELS) > (64'd1 << ADDR_W)) begin : g_size_check
      $error("cam_frame_writer: crop window does not fit in the RAM address space");
   end

   cam_state_e        state_q, state_d;
   logic              vs_q, hr_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [PIX_W-1:0]  wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              serr_q, serr_d;

   logic vs_rise_c, vs_fall_c;
   logic clear_c, step_c, line_end_c;
   logic win_hit_c;

   assign vs_rise_c = vsync & ~vs_q;
   assign vs_fall_c = ~vsync & vs_q;

   cam_win_counter #(
      .SRC_W  (SRC_W),
      .SRC_H  (SRC_H),
      .WIN_X0 (WIN_X0),
      .WIN_Y0 (WIN_Y0),
      .WIN_W  (WIN_W),
      .WIN_H  (WIN_H)
   ) u_win (
      .csi_pclk    (csi_pclk),
      .reset_n     (reset_n),
      .clear_i     (clear_c),
      .step_i      (step_c),
      .line_end_i  (line_end_c),
      .win_hit_c_o (win_hit_c)
   );

   // Next-state, address counter and RAM port stage.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      serr_d     = 1'b0;
      clear_c    = 1'b0;
      step_c     = 1'b0;
      line_end_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (!enable)        state_d = ST_IDLE;
            else if (vs_rise_c) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            clear_c = 1'b1;
            addr_d  = '0;
            if (vs_fall_c) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            step_c     = pix_valid & href;
            line_end_c = hr_q & ~href;
            if (step_c && win_hit_c) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = pix_data;
               addr_d  = addr_q + ADDR_W'(1);
            end
            // The final write takes priority over a coincident vsync rise.
            if (step_c && win_hit_c && (addr_q == LAST_ADDR)) begin
               state_d = ST_DONE;
            end else if (vs_rise_c) begin
               serr_d  = 1'b1;
               state_d = ST_SYNC;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_WAIT_VS;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_SYNC) || (state_d == ST_ACTIVE);
   end

   always_ff @(posedge csi_pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         vs_q    <= 1'b0;
         hr_q    <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_q    <= vsync;
         hr_q    <= href;
         addr_q  <= addr_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         serr_q  <= serr_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = waddr_q;
   assign mem_wdata  = wdata_q;
   assign frame_busy = busy_q;
   assign frame_done = done_q;
   assign short_err  = serr_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer on an 8x6 source with a 4x3 window at (2,1).
module tb_cam_frame_writer;

   localparam int unsigned SRC_W  = 8;
   localparam int unsigned SRC_H  = 6;
   localparam int unsigned WIN_X0 = 2;
   localparam int unsigned WIN_Y0 = 1;
   localparam int unsigned WIN_W  = 4;
   localparam int unsigned WIN_H  = 3;
   localparam int unsigned ADDR_W = 4;

   logic              csi_pclk;
   logic              reset_n;
   logic              enable;
   logic              vsync;
   logic              href;
   logic              pix_valid;
   logic [15:0]       pix_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              frame_busy;
   logic              frame_done;
   logic              short_err;

   int tests = 0;
   int fails = 0;

   logic [19:0] wq[$];
   int done_cnt = 0;
   int serr_cnt = 0;
   int wbase, dbase, sbase;

   cam_frame_writer #(
      .SRC_W  (SRC_W),
      .SRC_H  (SRC_H),
      .WIN_X0 (WIN_X0),
      .WIN_Y0 (WIN_Y0),
      .WIN_W  (WIN_W),
      .WIN_H  (WIN_H),
      .ADDR_W (ADDR_W)
   ) dut (
      .csi_pclk   (csi_pclk),
      .reset_n    (reset_n),
      .enable     (enable),
      .vsync      (vsync),
      .href       (href),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .short_err  (short_err)
   );

   initial csi_pclk = 1'b0;
   always #5 csi_pclk = ~csi_pclk;

   // Log RAM writes and pulse cycles away from the active edge.
   always @(negedge csi_pclk) begin
      if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
      if (frame_done === 1'b1) done_cnt++;
      if (short_err === 1'b1) serr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge csi_pclk);
      #1;
   endtask

   function automatic logic [15:0] exp_pix(input logic [3:0] tag, input int x, input int y);
      return {tag, 4'(y), 8'(x)};
   endfunction

   task automatic mark();
      wbase = wq.size();
      dbase = done_cnt;
      sbase = serr_cnt;
   endtask

   task automatic vsync_pulse();
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(3);
   endtask

   // One pixel every other cycle; the (3,2) pixel optionally carries BEEF and is checked at latency 1.
   task automatic send_line(input int y, input int npix, input logic [3:0] tag, input bit beef);
      bit is_beef;
      href = 1'b1;
      for (int x = 0; x < npix; x++) begin
         is_beef   = beef && (x == 3) && (y == 2);
         pix_valid = 1'b1;
         pix_data  = is_beef ? 16'hBEEF : exp_pix(tag, x, y);
         tick(1);
         pix_valid = 1'b0;
         if (is_beef) begin
            check("beef mem_we", 32'(mem_we), 32'd1);
            check("beef mem_addr", 32'(mem_addr), 32'd5);
            check("beef mem_wdata", 32'(mem_wdata), 32'hBEEF);
         end
         tick(1);
      end
      href = 1'b0;
      tick(2);
   endtask

   task automatic send_lines(input int y0, input int y1, input int npix,
                             input logic [3:0] tag, input bit beef);
      for (int y = y0; y < y1; y++) send_line(y, npix, tag, beef);
   endtask

   task automatic check_writes(input string name, input logic [3:0] tag, input int n, input bit beef);
      logic [19:0] exp;
      check({name, " write count"}, 32'(wq.size() - wbase), 32'(n));
      for (int i = 0; i < n && (wbase + i) < wq.size(); i++) begin
         exp[19:16] = 4'(i);
         exp[15:0]  = (beef && i == 5) ? 16'hBEEF : exp_pix(tag, 2 + i % 4, 1 + i / 4);
         check({name, " addr/data"}, 32'(wq[wbase + i]), 32'(exp));
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      vsync     = 1'b0;
      href      = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      tick(2);

      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_addr", 32'(mem_addr), 32'd0);
      check("reset mem_wdata", 32'(mem_wdata), 32'd0);
      check("reset frame_busy", 32'(frame_busy), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset short_err", 32'(short_err), 32'd0);

      reset_n = 1'b1;
      enable  = 1'b1;
      tick(3);

      // Full frame with the BEEF pixel at (3,2).
      mark();
      vsync_pulse();
      check("f1 busy in active", 32'(frame_busy), 32'd1);
      send_lines(0, 6, 8, 4'h1, 1'b1);
      tick(4);
      check_writes("f1", 4'h1, 12, 1'b1);
      check("f1 frame_done count", 32'(done_cnt - dbase), 32'd1);
      check("f1 short_err count", 32'(serr_cnt - sbase), 32'd0);
      check("f1 busy after done", 32'(frame_busy), 32'd0);

      // Short frame: vsync rises after six window writes.
      mark();
      vsync_pulse();
      send_lines(0, 2, 8, 4'h2, 1'b0);
      send_line(2, 4, 4'h2, 1'b0);
      vsync_pulse();
      check_writes("short", 4'h2, 6, 1'b0);
      check("short short_err cycles", 32'(serr_cnt - sbase), 32'd1);
      check("short frame_done count", 32'(done_cnt - dbase), 32'd0);
      check("short busy after restart", 32'(frame_busy), 32'd1);

      // Restarted frame must begin again at address 0.
      mark();
      send_lines(0, 6, 8, 4'h3, 1'b0);
      tick(4);
      check_writes("restart", 4'h3, 12, 1'b0);
      check("restart frame_done count", 32'(done_cnt - dbase), 32'd1);
      check("restart short_err count", 32'(serr_cnt - sbase), 32'd0);

      // Overlong lines: pixels beyond SRC_W are dropped.
      mark();
      vsync_pulse();
      send_lines(0, 6, 10, 4'h4, 1'b0);
      tick(4);
      check_writes("long", 4'h4, 12, 1'b0);
      check("long frame_done count", 32'(done_cnt - dbase), 32'd1);

      // enable dropped mid-frame: frame completes, then no further capture.
      mark();
      vsync_pulse();
      send_lines(0, 2, 8, 4'h5, 1'b0);
      enable = 1'b0;
      send_lines(2, 6, 8, 4'h5, 1'b0);
      tick(4);
      check_writes("disable", 4'h5, 12, 1'b0);
      check("disable frame_done count", 32'(done_cnt - dbase), 32'd1);
      mark();
      vsync_pulse();
      check("idle busy", 32'(frame_busy), 32'd0);
      send_lines(0, 6, 8, 4'h6, 1'b0);
      tick(4);
      check("idle write count", 32'(wq.size() - wbase), 32'd0);
      check("idle frame_done count", 32'(done_cnt - dbase), 32'd0);

      // Reset mid-frame.
      enable = 1'b1;
      tick(3);
      mark();
      vsync_pulse();
      send_lines(0, 2, 8, 4'h8, 1'b0);
      check("mid busy before reset", 32'(frame_busy), 32'd1);
      check("mid addr before reset", 32'(mem_addr), 32'd3);
      check("mid wdata before reset", 32'(mem_wdata), 32'(exp_pix(4'h8, 5, 1)));
      reset_n = 1'b0;
      #2;
      check("mid reset mem_we", 32'(mem_we), 32'd0);
      check("mid reset mem_addr", 32'(mem_addr), 32'd0);
      check("mid reset mem_wdata", 32'(mem_wdata), 32'd0);
      check("mid reset frame_busy", 32'(frame_busy), 32'd0);
      check("mid reset frame_done", 32'(frame_done), 32'd0);
      check("mid reset short_err", 32'(short_err), 32'd0);
      tick(3);
      reset_n = 1'b1;
      tick(3);
      check("mid write count", 32'(wq.size() - wbase), 32'd4);
      check("mid frame_done count", 32'(done_cnt - dbase), 32'd0);
      check("mid short_err count", 32'(serr_cnt - sbase), 32'd0);

      mark();
      vsync_pulse();
      send_lines(0, 6, 8, 4'h9, 1'b0);
      tick(4);
      check_writes("post reset", 4'h9, 12, 1'b0);
      check("post reset frame_done count", 32'(done_cnt - dbase), 32'd1);
      check("post reset short_err count", 32'(serr_cnt - sbase), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
